// File: rtl/alu16_sequencer_if.sv
// Request handshake and 8-bit ALU bus bundles for the 16-bit
// sequencer.
interface alu16_req_if #(
   parameter int W_BYTE = 8
);
   logic                  start;
   logic [2:0]            op;
   logic [2*W_BYTE-1:0]   a;
   logic [2*W_BYTE-1:0]   b;
   logic                  cin;
   logic                  ready;
   logic                  done;
   logic [2*W_BYTE-1:0]   result;
   logic                  zero;
   logic                  carry;

   modport master (
      output start, op, a, b, cin,
      input  ready, done, result, zero, carry
   );

   modport slave (
      input  start, op, a, b, cin,
      output ready, done, result, zero, carry
   );
endinterface

interface alu8_bus_if #(
   parameter int W_BYTE = 8
);
   logic [W_BYTE-1:0] alu_a;
   logic [W_BYTE-1:0] alu_b;
   logic              alu_carry_in;
   logic              alu_is_shift;
   logic              alu_update_z_c;
   logic [1:0]        alu_scode;
   logic [2:0]        alu_acode;
   logic [W_BYTE-1:0] alu_r;
   logic              alu_zero;
   logic              alu_carry_out;

   modport master (
      output alu_a, alu_b, alu_carry_in, alu_is_shift,
      output alu_update_z_c, alu_scode, alu_acode,
      input  alu_r, alu_zero, alu_carry_out
   );

   modport slave (
      input  alu_a, alu_b, alu_carry_in, alu_is_shift,
      input  alu_update_z_c, alu_scode, alu_acode,
      output alu_r, alu_zero, alu_carry_out
   );
endinterface

// File: rtl/alu16_sequencer.sv
// Runs a 16-bit op through an 8-bit ALU in two passes,
// low byte first, chaining the low-byte carry/borrow.
module alu16_sequencer #(
   parameter int W_BYTE = 8
) (
   input logic        clk,
   input logic        rst,
   alu16_req_if.slave req,
   alu8_bus_if.master alu
);
   localparam int W = 2 * W_BYTE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic              cin_q, cin_d;
   logic [W_BYTE-1:0] lo_q, lo_d;
   logic              c_lo_q, c_lo_d;
   logic [W-1:0]      result_q, result_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;

   logic              is_arith;
   logic              uses_cin;
   logic [W-1:0]      full_word;
   logic              unused_alu_zero;

   assign is_arith        = ~op_q[2];
   assign uses_cin        = is_arith & op_q[0];
   assign full_word       = {alu.alu_r, lo_q};
   assign unused_alu_zero = alu.alu_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cin_q    <= 1'b0;
         lo_q     <= '0;
         c_lo_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cin_q    <= cin_d;
         lo_q     <= lo_d;
         c_lo_q   <= c_lo_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req.start) state_d = S_LO;
         S_LO:   state_d = S_HI;
         S_HI:   state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cin_d    = cin_q;
      lo_d     = lo_q;
      c_lo_d   = c_lo_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      unique case (state_q)
         S_IDLE: begin
            if (req.start) begin
               a_d   = req.a;
               b_d   = req.b;
               op_d  = req.op;
               cin_d = req.cin;
            end
         end
         S_LO: begin
            lo_d   = alu.alu_r;
            c_lo_d = alu.alu_carry_out;
         end
         S_HI: begin
            result_d = full_word;
            zero_d   = (full_word == '0);
            carry_d  = is_arith & alu.alu_carry_out;
         end
         default: ;
      endcase
   end

   always_comb begin
      req.ready          = 1'b0;
      req.done           = 1'b0;
      alu.alu_a          = '0;
      alu.alu_b          = '0;
      alu.alu_carry_in   = 1'b0;
      alu.alu_is_shift   = 1'b0;
      alu.alu_update_z_c = 1'b0;
      alu.alu_scode      = 2'b00;
      alu.alu_acode      = 3'b000;
      unique case (state_q)
         S_IDLE: req.ready = 1'b1;
         S_LO: begin
            alu.alu_a          = a_q[W_BYTE-1:0];
            alu.alu_b          = b_q[W_BYTE-1:0];
            alu.alu_acode      = op_q;
            alu.alu_carry_in   = uses_cin & cin_q;
            alu.alu_update_z_c = is_arith;
         end
         S_HI: begin
            // high pass of ADD/SUB always uses the with-carry form
            alu.alu_a          = a_q[W-1:W_BYTE];
            alu.alu_b          = b_q[W-1:W_BYTE];
            alu.alu_acode      = is_arith ?
                                 {1'b0, op_q[1], 1'b1} : op_q;
            alu.alu_carry_in   = is_arith & c_lo_q;
            alu.alu_update_z_c = is_arith;
         end
         S_DONE: req.done = 1'b1;
         default: ;
      endcase
   end

   assign req.result = result_q;
   assign req.zero   = zero_q;
   assign req.carry  = carry_q;
endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with an 8-bit ALU stand-in
// and a whole-word reference model checked every cycle.
module tb_alu16_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;

   alu16_req_if #(.W_BYTE(8)) req ();
   alu8_bus_if  #(.W_BYTE(8)) bus ();

   alu16_sequencer #(.W_BYTE(8)) dut (
      .clk (clk),
      .rst (rst),
      .req (req.slave),
      .alu (bus.master)
   );

   always #5 clk = ~clk;

   // 8-bit ALU stand-in; subtract reports borrow on carry_out
   always_comb begin
      logic [8:0] t;
      t = '0;
      case (bus.alu_acode)
         3'd0: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         3'd1: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
                   + {8'd0, bus.alu_carry_in};
         3'd2: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         3'd3: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}
                   - {8'd0, bus.alu_carry_in};
         3'd4: t = {1'b0, bus.alu_a & bus.alu_b};
         3'd5: t = {1'b0, bus.alu_a | bus.alu_b};
         3'd6: t = {1'b0, bus.alu_a ^ bus.alu_b};
         default: t = {1'b0, ~(bus.alu_a & bus.alu_b)};
      endcase
      bus.alu_r         = t[7:0];
      bus.alu_carry_out = t[8];
      bus.alu_zero      = (t[7:0] == 8'd0);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] ref_op(logic [2:0] op,
                                          logic [15:0] a,
                                          logic [15:0] b,
                                          logic cin);
      logic [16:0] r;
      case (op)
         3'd0: r = {1'b0, a} + {1'b0, b};
         3'd1: r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         3'd2: r = {1'b0, a} - {1'b0, b};
         3'd3: r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
         3'd4: r = {1'b0, a & b};
         3'd5: r = {1'b0, a | b};
         3'd6: r = {1'b0, a ^ b};
         default: r = {1'b0, ~(a & b)};
      endcase
      return r;
   endfunction

   // Reference: a request takes 3 cycles to report; results
   // change only when it reports.
   int          phase = 0;
   logic [16:0] pend;
   logic [15:0] m_res = '0;
   logic        m_z = 1'b0;
   logic        m_c = 1'b0;
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         phase = 0;
         m_res = '0;
         m_z   = 1'b0;
         m_c   = 1'b0;
      end else if (phase == 0) begin
         if (req.start) begin
            pend  = ref_op(req.op, req.a, req.b, req.cin);
            phase = 1;
         end
      end else begin
         if (phase == 2) begin
            m_res = pend[15:0];
            m_z   = (pend[15:0] == 16'd0);
            m_c   = pend[16];
         end
         phase = (phase == 3) ? 0 : phase + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", {31'd0, req.ready}, {31'd0, phase == 0});
         chk("done", {31'd0, req.done}, {31'd0, phase == 3});
         chk("result", {16'd0, req.result}, {16'd0, m_res});
         chk("zero", {31'd0, req.zero}, {31'd0, m_z});
         chk("carry", {31'd0, req.carry}, {31'd0, m_c});
         chk("is_shift", {31'd0, bus.alu_is_shift}, 32'd0);
         chk("scode", {30'd0, bus.alu_scode}, 32'd0);
      end
   end

   logic [2:0] lo_acode, hi_acode;
   logic       lo_ci, hi_ci, lo_upd, hi_upd, lo_co;
   logic [7:0] lo_r;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(string nm, logic [2:0] op,
                         logic [15:0] a, logic [15:0] b,
                         logic cin, logic [15:0] e_res,
                         logic e_z, logic e_c);
      req.start = 1'b1;
      req.op    = op;
      req.a     = a;
      req.b     = b;
      req.cin   = cin;
      tick();
      req.start = 1'b0;
      req.a     = 16'h5A5A;
      req.b     = 16'hC3C3;
      lo_acode  = bus.alu_acode;
      lo_ci     = bus.alu_carry_in;
      lo_upd    = bus.alu_update_z_c;
      lo_r      = bus.alu_r;
      lo_co     = bus.alu_carry_out;
      tick();
      hi_acode  = bus.alu_acode;
      hi_ci     = bus.alu_carry_in;
      hi_upd    = bus.alu_update_z_c;
      tick();
      chk({nm, "_done"}, {31'd0, req.done}, 32'd1);
      chk({nm, "_res"}, {16'd0, req.result}, {16'd0, e_res});
      chk({nm, "_z"}, {31'd0, req.zero}, {31'd0, e_z});
      chk({nm, "_c"}, {31'd0, req.carry}, {31'd0, e_c});
      tick();
   endtask

   int         n_done;
   logic [15:0] r1, r2;

   initial begin
      req.start = 1'b0;
      req.op    = 3'd0;
      req.a     = '0;
      req.b     = '0;
      req.cin   = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst_ready", {31'd0, req.ready}, 32'd1);
      chk("rst_result", {16'd0, req.result}, 32'd0);
      chk("rst_acode", {29'd0, bus.alu_acode}, 32'd0);
      chk("rst_upd", {31'd0, bus.alu_update_z_c}, 32'd0);
      chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
      rst = 1'b0;
      tick();

      run_op("add_ff", 3'd0, 16'h00FF, 16'h0001, 1'b0,
             16'h0100, 1'b0, 1'b0);
      chk("add_lo_r", {24'd0, lo_r}, 32'h00);
      chk("add_lo_co", {31'd0, lo_co}, 32'd1);
      chk("add_lo_acode", {29'd0, lo_acode}, 32'd0);
      chk("add_hi_acode", {29'd0, hi_acode}, 32'd1);
      chk("add_hi_ci", {31'd0, hi_ci}, 32'd1);
      chk("add_upd", {30'd0, lo_upd, hi_upd}, 32'd3);

      run_op("add_ovf", 3'd0, 16'hFFFF, 16'h0001, 1'b0,
             16'h0000, 1'b1, 1'b1);

      run_op("sub_eq", 3'd2, 16'h1234, 16'h1234, 1'b1,
             16'h0000, 1'b1, 1'b0);
      chk("sub_lo_acode", {29'd0, lo_acode}, 32'd2);
      chk("sub_hi_acode", {29'd0, hi_acode}, 32'd3);
      chk("sub_lo_ci", {31'd0, lo_ci}, 32'd0);

      run_op("xor", 3'd6, 16'hAAAA, 16'h5555, 1'b0,
             16'hFFFF, 1'b0, 1'b0);
      chk("xor_upd", {30'd0, lo_upd, hi_upd}, 32'd0);
      chk("xor_hi_acode", {29'd0, hi_acode}, 32'd6);

      run_op("nand", 3'd7, 16'hFFFF, 16'h00FF, 1'b1,
             16'hFF00, 1'b0, 1'b0);
      chk("nand_upd", {30'd0, lo_upd, hi_upd}, 32'd0);
      chk("nand_hi_ci", {31'd0, hi_ci}, 32'd0);

      run_op("addc", 3'd1, 16'h0001, 16'h0001, 1'b1,
             16'h0003, 1'b0, 1'b0);
      chk("addc_lo_ci", {31'd0, lo_ci}, 32'd1);

      run_op("subc", 3'd3, 16'h0000, 16'h0001, 1'b1,
             16'hFFFE, 1'b0, 1'b1);

      run_op("or", 3'd5, 16'h0F00, 16'h00F0, 1'b0,
             16'h0FF0, 1'b0, 1'b0);

      // start held high for 8 cycles
      n_done    = 0;
      req.start = 1'b1;
      req.op    = 3'd0;
      req.a     = 16'h0001;
      req.b     = 16'h0002;
      r1        = '0;
      r2        = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 1) begin
            req.a = 16'h0100;
            req.b = 16'h0200;
         end
         if (req.done) n_done++;
         if (i == 3) r1 = req.result;
         if (i == 7) r2 = req.result;
      end
      req.start = 1'b0;
      tick();
      tick();
      chk("hold_ndone", n_done, 32'd2);
      chk("hold_r1", {16'd0, r1}, 32'h0003);
      chk("hold_r2", {16'd0, r2}, 32'h0300);

      // reset during HI aborts the operation
      req.start = 1'b1;
      req.a     = 16'h0001;
      req.b     = 16'h0001;
      tick();
      req.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", {31'd0, req.ready}, 32'd1);
      chk("abort_done", {31'd0, req.done}, 32'd0);
      chk("abort_res", {16'd0, req.result}, 32'd0);
      tick();
      chk("abort_nodone", {31'd0, req.done}, 32'd0);
      run_op("post_rst", 3'd0, 16'h0001, 16'h0001, 1'b0,
             16'h0002, 1'b0, 1'b0);

      // simultaneous reset and start drops the request
      rst       = 1'b1;
      req.start = 1'b1;
      tick();
      rst       = 1'b0;
      req.start = 1'b0;
      chk("rst_start_ready", {31'd0, req.ready}, 32'd1);
      tick();
      tick();
      tick();
      chk("rst_start_res", {16'd0, req.result}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Initiator-side controller for the 8-bit combinational ALU.
- Accepts one 16-bit arithmetic or logic request through a start/ready/done handshake.
- Drives the ALU twice, low byte then high byte, chaining the low-byte carry into the high-byte add-with-carry or subtract-with-borrow.
- Registers the 16-bit result and the 16-bit zero/carry flags. Lets the 8-bit datapath execute 16-bit operations without a wider ALU.

Parameters:
- W_BYTE, 8, ALU operand width; the request width is 2*W_BYTE.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; accepted only when ready=1
- op  input  3  operation: 000 ADD, 001 ADDC, 010 SUB, 011 SUBC, 100 AND, 101 OR, 110 XOR, 111 NAND
- a  input  16  operand A
- b  input  16  operand B
- cin  input  1  carry/borrow in; used by ADDC and SUBC only
- ready  output  1  high in IDLE
- done  output  1  one-cycle pulse; result and flags are valid from this cycle
- result  output  16  registered result
- zero  output  1  registered: result==0
- carry  output  1  registered: high-byte ALU carry_out for arithmetic ops, 0 for logic ops
- alu_a  output  8  ALU operand A
- alu_b  output  8  ALU operand B
- alu_carry_in  output  1  ALU carry_in
- alu_is_shift  output  1  constant 0
- alu_update_z_c  output  1  ALU flag-update enable
- alu_scode  output  2  constant 00
- alu_acode  output  3  ALU operation code
- alu_r  input  8  ALU result
- alu_zero  input  1  ALU zero; unused, the zero flag is computed locally
- alu_carry_out  input  1  ALU carry_out

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values:
  - State = IDLE, ready=1, done=0, result=0, zero=0, carry=0.
  - All alu_* outputs = 0 (acode 000, update_z_c 0).
  - Internal latches cleared.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - ready=1, alu_update_z_c=0.
  - start=1 captures a, b, op, cin into internal registers and moves to LO.
  - start=0 stays in IDLE.
- LO:
  - alu_a = a_q[7:0], alu_b = b_q[7:0], alu_acode = op_q.
  - alu_carry_in = cin_q for ADDC/SUBC, 0 otherwise.
  - alu_update_z_c = 1 for op 000-011, 0 for logic ops.
  - At the clock edge: lo_q <= alu_r, c_lo_q <= alu_carry_out. Next state HI.
- HI:
  - alu_a = a_q[15:8], alu_b = b_q[15:8], alu_carry_in = c_lo_q.
  - alu_acode: ADD/ADDC -> 001; SUB/SUBC -> 011; logic ops -> op_q, with carry_in forced to 0.
  - At the clock edge:
    - result <= {alu_r, lo_q}.
    - zero <= ({alu_r, lo_q} == 0).
    - carry <= alu_carry_out for arithmetic ops, 0 for logic ops.
  - Next state DONE.
- DONE: done=1 for exactly one cycle, ready=0, then IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+2 (3 cycles). Throughput is one request per 4 cycles.
- ALU operand stability: operands and codes are driven from registered state only and stay stable for a whole cycle. The ALU output is sampled only at the end of that cycle. The ALU's internally latched flags are never relied on.
- start while ready=0 is ignored; no queuing.
- result, zero and carry hold their values until the next HI edge or reset.
- Inputs a, b, op and cin may change after acceptance without affecting the operation in flight.
- rst in any state aborts the operation: IDLE, outputs cleared, no done pulse.
- Simultaneous rst and start: rst wins and the request is dropped.

Test Plan:
- ADD 0x00FF+0x0001 (real ALU instantiated) -> in LO, alu_r=0x00 with carry 1; in HI, alu_acode=001 and alu_carry_in=1; done 3 cycles after start; result=0x0100, zero=0, carry=0.
- ADD 0xFFFF+0x0001 -> result=0x0000, zero=1, carry=1.
- SUB 0x1234-0x1234 -> result=0x0000, zero=1; alu_acode=010 in LO and 011 in HI.
- XOR 0xAAAA^0x5555, then NAND 0xFFFF,0x00FF -> result=0xFFFF with carry=0, then result=0xFF00 with zero=0; alu_update_z_c=0 in both steps.
- start held high for 8 cycles -> exactly two operations complete (done at cycles 3 and 7); start during LO/HI/DONE is ignored; changing a/b after acceptance leaves the result unchanged.
- rst asserted in HI of ADD 0x0001+0x0001 -> next cycle IDLE, ready=1, result=0, no done pulse; a following request completes normally.
